uart_dec_tx_sequencer: RTL

- Converts a 14-bit unsigned value (0–9999) into four ASCII decimal digits, most significant first.
- Optionally appends CR/LF after the digits.
- Sequences the bytes one at a time into the existing byte-level UART transmitter using its start/done handshake.
- Sits between the user/button logic and the UART TX core. It owns byte ordering, digit conversion and start-edge qualification.

---
 rtl/uart_dec_tx_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_dec_tx_sequencer.sv
// uart_dec_tx_sequencer
// Turns a 0..9999 value into four ASCII decimal digits (most significant
// first), optionally followed by CR/LF, and feeds them one byte at a time
// into a byte-level UART TX core through its start/done handshake.
// The conversion uses repeated subtraction of 1000/100/10, one step per
// cycle, so no divider or multiplier is needed.
module uart_dec_tx_sequencer #(
    parameter bit          APPEND_CRLF = 1'b1,
    parameter int unsigned CLAMP_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_send_data,
    input  logic        i_start,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    localparam logic [13:0] CLAMP_VAL = 14'(CLAMP_MAX);
    localparam logic [2:0]  LAST_IDX  = APPEND_CRLF ? 3'd5 : 3'd3;

    // Decimal weight used by the conversion step at a given digit position.
    function automatic logic [13:0] weight_of(input logic [1:0] idx);
        logic [13:0] w;
        case (idx)
            2'd0:    w = 14'd1000;
            2'd1:    w = 14'd100;
            default: w = 14'd10;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Byte to send for a given position in the frame.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [3:0] th,
                                              input logic [3:0] hu,
                                              input logic [3:0] te,
                                              input logic [3:0] on);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ascii_digit(th);
            3'd1:    b = ascii_digit(hu);
            3'd2:    b = ascii_digit(te);
            3'd3:    b = ascii_digit(on);
            3'd4:    b = 8'h0D;
            3'd5:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r,  state_s;
    logic [13:0] rem_r,    rem_s;
    logic [3:0]  dig_th_r, dig_th_s;
    logic [3:0]  dig_hu_r, dig_hu_s;
    logic [3:0]  dig_te_r, dig_te_s;
    logic [3:0]  dig_on_r, dig_on_s;
    logic [1:0]  widx_r,   widx_s;
    logic [2:0]  bidx_r,   bidx_s;
    logic        tx_start_r, tx_start_s;
    logic [7:0]  tx_data_r,  tx_data_s;
    logic        busy_r,     busy_s;
    logic        done_r,     done_s;
    logic        start_q_r;
    logic        start_edge_s;
    logic [13:0] weight_s;

    assign start_edge_s = i_start & ~start_q_r;
    assign weight_s     = weight_of(widx_r);

    assign o_tx_start = tx_start_r;
    assign o_tx_data  = tx_data_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

    // Next-state and next-output logic for the conversion/sequencing FSM.
    always_comb begin
        state_s    = state_r;
        rem_s      = rem_r;
        dig_th_s   = dig_th_r;
        dig_hu_s   = dig_hu_r;
        dig_te_s   = dig_te_r;
        dig_on_s   = dig_on_r;
        widx_s     = widx_r;
        bidx_s     = bidx_r;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    rem_s    = (i_send_data > CLAMP_VAL) ? CLAMP_VAL : i_send_data;
                    dig_th_s = 4'd0;
                    dig_hu_s = 4'd0;
                    dig_te_s = 4'd0;
                    dig_on_s = 4'd0;
                    widx_s   = 2'd0;
                    bidx_s   = 3'd0;
                    busy_s   = 1'b1;
                    state_s  = ST_CONV;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (rem_r >= weight_s) begin
                    rem_s = rem_r - weight_s;
                    case (widx_r)
                        2'd0:    dig_th_s = dig_th_r + 4'd1;
                        2'd1:    dig_hu_s = dig_hu_r + 4'd1;
                        default: dig_te_s = dig_te_r + 4'd1;
                    endcase
                end else if (widx_r == 2'd2) begin
                    // what is left after the tens is the ones digit
                    dig_on_s = rem_r[3:0];
                    state_s  = ST_LOAD;
                end else begin
                    widx_s = widx_r + 2'd1;
                end
            end
            ST_LOAD: begin
                if (!i_tx_busy) begin
                    tx_data_s  = frame_byte(bidx_r, dig_th_r, dig_hu_r, dig_te_r, dig_on_r);
                    tx_start_s = 1'b1;
                    state_s    = ST_WAIT_DONE;
                end else begin
                    state_s    = ST_LOAD;
                end
            end
            ST_WAIT_DONE: begin
                // a done coincident with our own start pulse belongs to an older byte
                if (i_tx_done && !tx_start_r) begin
                    if (bidx_r == LAST_IDX) begin
                        done_s  = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        bidx_s  = bidx_r + 3'd1;
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_FINISH: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rem_r      <= 14'd0;
            dig_th_r   <= 4'd0;
            dig_hu_r   <= 4'd0;
            dig_te_r   <= 4'd0;
            dig_on_r   <= 4'd0;
            widx_r     <= 2'd0;
            bidx_r     <= 3'd0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            start_q_r  <= 1'b1;
        end else begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            dig_th_r   <= dig_th_s;
            dig_hu_r   <= dig_hu_s;
            dig_te_r   <= dig_te_s;
            dig_on_r   <= dig_on_s;
            widx_r     <= widx_s;
            bidx_r     <= bidx_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            start_q_r  <= i_start;
        end
    end

endmodule
